// File: rtl/board_win_scanner_if.sv
// Scanner request/result bundle: the requester drives start and board, the scanner returns status and result.
interface board_win_scanner_if #(
    parameter int ROWS = 7,
    parameter int COLS = 7
) ();
    logic                       start;
    logic [2*ROWS*COLS-1:0]     board;
    logic                       busy;
    logic                       done;
    logic [1:0]                 winner;
    logic [5:0]                 win_cell;
    logic [1:0]                 win_dir;
    logic                       draw;

    modport master (output start, board, input busy, done, winner, win_cell, win_dir, draw);
    modport slave  (input start, board, output busy, done, winner, win_cell, win_dir, draw);
endinterface

// File: rtl/board_win_scanner.sv
// Sequential Connect-4 four-in-a-row detector: snapshot on start, one anchor per cycle, four directions each.
// Latency: win at anchor k -> done at edge k+1; no win -> edge N. Start is ignored while busy.
module board_win_scanner #(
    parameter int ROWS = 7,
    parameter int COLS = 7,
    parameter int RUN  = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    board_win_scanner_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = 6;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q;
    logic [2*N-1:0]  snap_q;
    logic [IW-1:0]   idx_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            empty_q;
    logic            busy_q;
    logic            done_q;
    logic            draw_q;
    logic [1:0]      winner_q;
    logic [1:0]      win_dir_q;
    logic [5:0]      win_cell_q;

    logic [1:0]      anchor;
    logic [3:0]      inb;
    logic [3:0]      match;
    logic [1:0]      hit_dir;

    function automatic logic [1:0] cell_at(input logic [2*N-1:0] b, input int k);
        cell_at = 2'b00;
        if (k >= 0 && k < N) cell_at = b[2*(N-1-k) +: 2];
    endfunction

    // Linear step between consecutive cells of a run: right, down, down-right, down-left.
    function automatic int dir_off(input int d);
        case (d)
            0:       dir_off = 1;
            1:       dir_off = COLS;
            2:       dir_off = COLS + 1;
            default: dir_off = COLS - 1;
        endcase
    endfunction

    always_comb begin
        anchor = cell_at(snap_q, int'(idx_q));
        inb[0] = int'(col_q) <= COLS - RUN;
        inb[1] = int'(row_q) <= ROWS - RUN;
        inb[2] = inb[0] && inb[1];
        inb[3] = (int'(col_q) >= RUN - 1) && inb[1];
        match  = '0;
        for (int d = 0; d < 4; d++) begin
            match[d] = inb[d] && (anchor == 2'b01 || anchor == 2'b10);
            for (int s = 1; s < RUN; s++) begin
                if (cell_at(snap_q, int'(idx_q) + s * dir_off(d)) != anchor) match[d] = 1'b0;
            end
        end
        hit_dir = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (match[d]) hit_dir = 2'(d);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            empty_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            draw_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_dir_q  <= 2'd0;
            win_cell_q <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        snap_q  <= bus.board;
                        idx_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        empty_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    empty_q <= empty_q | (anchor == 2'b00);
                    if (|match) begin
                        winner_q   <= anchor;
                        win_cell_q <= idx_q;
                        win_dir_q  <= hit_dir;
                        draw_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else if (idx_q == IW'(N - 1)) begin
                        winner_q   <= 2'b00;
                        win_cell_q <= 6'd0;
                        win_dir_q  <= 2'd0;
                        // The last cell's emptiness is not yet folded into empty_q.
                        draw_q     <= ~(empty_q | (anchor == 2'b00));
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.winner   = winner_q;
    assign bus.win_cell = win_cell_q;
    assign bus.win_dir  = win_dir_q;
    assign bus.draw     = draw_q;
endmodule

// File: tb/tb_board_win_scanner.sv
// Scoreboard bench for board_win_scanner: directed boards push expected results, a negedge monitor checks each done.
module tb_board_win_scanner;
    typedef struct {
        logic [1:0] w;
        logic [5:0] wc;
        logic [1:0] wd;
        logic       dr;
        int         t;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   cyc  = 0;
    int   nvec = 0;
    int   nmis = 0;
    logic done_prev = 1'b0;
    exp_t q[$];

    board_win_scanner_if #(.ROWS(7), .COLS(7)) bif ();

    board_win_scanner #(.ROWS(7), .COLS(7), .RUN(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bif)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [97:0] put(input logic [97:0] b, input int k, input logic [1:0] v);
        logic [97:0] r;
        r = b;
        r[2*(48-k) +: 2] = v;
        return r;
    endfunction

    // Pairs of columns alternate, flipping each row: no run longer than two in any direction.
    function automatic logic [97:0] alt_board();
        logic [97:0] r;
        r = '0;
        for (int rr = 0; rr < 7; rr++)
            for (int c = 0; c < 7; c++)
                r = put(r, rr*7 + c, (((c/2) + rr) % 2 == 0) ? 2'b01 : 2'b10);
        return r;
    endfunction

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (done_prev) chk("busy_low_after_done", int'(bif.busy), 0);
        done_prev = bif.done;
        if (bif.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_edge", cyc, e.t);
                chk("busy_at_done", int'(bif.busy), 1);
                chk("winner", int'(bif.winner), int'(e.w));
                chk("win_cell", int'(bif.win_cell), int'(e.wc));
                chk("win_dir", int'(bif.win_dir), int'(e.wd));
                chk("draw", int'(bif.draw), int'(e.dr));
            end
        end
    end

    task automatic start_scan(input logic [97:0] b, input logic [1:0] w, input logic [5:0] wc,
                              input logic [1:0] wd, input logic dr, input int lat);
        exp_t e;
        @(negedge CLOCK_50);
        bif.board = b;
        bif.start = 1'b1;
        e.w = w; e.wc = wc; e.wd = wd; e.dr = dr; e.t = cyc + 1 + lat;
        q.push_back(e);
        @(negedge CLOCK_50);
        bif.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || bif.busy) && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 200) begin
            chk("scan_timeout", n, 0);
            q.delete();
        end
        @(negedge CLOCK_50);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},     int'(bif.busy),     0);
        chk({tag, "_done"},     int'(bif.done),     0);
        chk({tag, "_winner"},   int'(bif.winner),   0);
        chk({tag, "_win_cell"}, int'(bif.win_cell), 0);
        chk({tag, "_win_dir"},  int'(bif.win_dir),  0);
        chk({tag, "_draw"},     int'(bif.draw),     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        logic [97:0] b2, b3, b4, b4w, b5;
        reset     = 1'b1;
        bif.start = 1'b0;
        bif.board = '0;
        b2  = put(put(put(put('0, 42, 2'b01), 43, 2'b01), 44, 2'b01), 45, 2'b01);
        b3  = put(put(put(put('0, 3, 2'b10), 10, 2'b10), 17, 2'b10), 24, 2'b10);
        b4  = put(put(put(put('0, 6, 2'b01), 12, 2'b01), 18, 2'b01), 24, 2'b01);
        b4w = put(put(put(put('0, 5, 2'b01), 6, 2'b01), 7, 2'b01), 8, 2'b01);
        b5  = alt_board();
        repeat (3) @(negedge CLOCK_50);
        check_zero("reset");
        reset = 1'b0;

        start_scan('0, 2'b00, 6'd0, 2'd0, 1'b0, 49);              wait_idle();
        start_scan(b2, 2'b01, 6'd42, 2'd0, 1'b0, 43);             wait_idle();
        start_scan(b3, 2'b10, 6'd3, 2'd1, 1'b0, 4);               wait_idle();
        start_scan(b4, 2'b01, 6'd6, 2'd3, 1'b0, 7);               wait_idle();
        start_scan(b4w, 2'b00, 6'd0, 2'd0, 1'b0, 49);             wait_idle();
        start_scan(b5, 2'b00, 6'd0, 2'd0, 1'b1, 49);              wait_idle();
        start_scan(put(b5, 0, 2'b00), 2'b00, 6'd0, 2'd0, 1'b0, 49);  wait_idle();
        start_scan(put(b5, 48, 2'b00), 2'b00, 6'd0, 2'd0, 1'b0, 49); wait_idle();

        // Second start at edge 10 of a running scan must be dropped.
        start_scan(b2, 2'b01, 6'd42, 2'd0, 1'b0, 43);
        repeat (9) @(negedge CLOCK_50);
        bif.board = b3;
        bif.start = 1'b1;
        @(negedge CLOCK_50);
        bif.start = 1'b0;
        wait_idle();
        repeat (60) @(negedge CLOCK_50);

        // Reset at edge 20 aborts the scan: outputs clear and no done appears.
        @(negedge CLOCK_50);
        bif.board = '0;
        bif.start = 1'b1;
        @(negedge CLOCK_50);
        bif.start = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1 reset = 1'b1;
        #2 check_zero("midreset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (60) @(negedge CLOCK_50);

        start_scan(b3, 2'b10, 6'd3, 2'd1, 1'b0, 4);               wait_idle();
        repeat (5) @(negedge CLOCK_50);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
